// File: rtl/mips_pkg.sv
// Constants shared by the MIPS pipeline stages (fetch, decode, debug unit).
package mips_pkg;

  localparam int unsigned NB_PC       = 32;
  localparam int unsigned NB_INSTR    = 32;
  localparam logic [NB_PC-1:0]    PC_INCR     = 32'd4;
  localparam logic [NB_INSTR-1:0] NOP_INSTR   = '0;
  localparam logic [NB_INSTR-1:0] HALT_INSTR  = '1;
  localparam logic [5:0]          OPCODE_HALT = 6'b111111;

  function automatic logic is_halt(input logic [NB_INSTR-1:0] instr);
    return (instr[31:26] == OPCODE_HALT) && (instr == HALT_INSTR);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Control, program-load and IF/ID signals of the fetch stage.
interface instruction_fetch_if #(
  parameter int NB_ADDR = 8
);
  import mips_pkg::*;

  logic                i_enable;
  logic                i_stall;
  logic                i_jump;
  logic [NB_PC-1:0]    i_jump_addr;
  logic                i_prog_we;
  logic [NB_ADDR-1:0]  i_prog_addr;
  logic [NB_INSTR-1:0] i_prog_data;
  logic [NB_PC-1:0]    o_pc;
  logic [NB_PC-1:0]    o_pc4;
  logic [NB_INSTR-1:0] o_instruction;
  logic                o_halt;

  modport master (
    output i_enable, i_stall, i_jump, i_jump_addr,
           i_prog_we, i_prog_addr, i_prog_data,
    input  o_pc, o_pc4, o_instruction, o_halt
  );

  modport slave (
    input  i_enable, i_stall, i_jump, i_jump_addr,
           i_prog_we, i_prog_addr, i_prog_data,
    output o_pc, o_pc4, o_instruction, o_halt
  );

endinterface

// File: rtl/instruction_memory.sv
// Word-addressed program memory: synchronous write, asynchronous read, no reset.
module instruction_memory
  import mips_pkg::*;
#(
  parameter int NB_ADDR = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [NB_ADDR-1:0]  waddr,
  input  logic [NB_INSTR-1:0] wdata,
  input  logic [NB_ADDR-1:0]  raddr,
  output logic [NB_INSTR-1:0] rdata
);

  logic [NB_INSTR-1:0] mem [0:(1 << NB_ADDR) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, program memory and IF/ID register.
// Optional HALT detection enabled by defining IFETCH_HALT_EN.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int               NB_ADDR  = 8,
  parameter logic [NB_PC-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  instruction_fetch_if.slave  bus
);

  logic [NB_PC-1:0]    pc;
  logic [NB_PC-1:0]    pc_next4;
  logic [NB_PC-1:0]    if_pc4;
  logic [NB_INSTR-1:0] if_instr;
  logic [NB_INSTR-1:0] fetch_word;
  logic [NB_ADDR-1:0]  idx;
  logic                run;

  assign idx      = pc[NB_ADDR+1:2];
  assign pc_next4 = pc + PC_INCR;

  instruction_memory #(
    .NB_ADDR (NB_ADDR)
  ) u_imem (
    .clk   (i_clk),
    .we    (bus.i_prog_we),
    .waddr (bus.i_prog_addr),
    .wdata (bus.i_prog_data),
    .raddr (idx),
    .rdata (fetch_word)
  );

`ifdef IFETCH_HALT_EN
  logic halted;
  logic fetch_halt;

  assign fetch_halt = is_halt(fetch_word);
  assign run = !bus.i_prog_we && bus.i_enable && !halted && !bus.i_stall;

  always_ff @(posedge i_clk) begin
    if (!i_reset)                              halted <= 1'b0;
    else if (run && !bus.i_jump && fetch_halt) halted <= 1'b1;
  end

  assign bus.o_halt = halted;
`else
  assign run = !bus.i_prog_we && bus.i_enable && !bus.i_stall;
  assign bus.o_halt = 1'b0;
`endif

  // A stall also masks i_jump: decode re-presents the branch once it clears.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pc       <= RESET_PC;
      if_instr <= NOP_INSTR;
      if_pc4   <= '0;
    end else if (run) begin
      if (bus.i_jump) begin
        pc       <= bus.i_jump_addr;
        if_instr <= NOP_INSTR;
        if_pc4   <= '0;
      end else begin
        if_instr <= fetch_word;
        if_pc4   <= pc_next4;
`ifdef IFETCH_HALT_EN
        if (!fetch_halt) pc <= pc_next4;
`else
        pc <= pc_next4;
`endif
      end
    end
  end

  assign bus.o_pc          = pc;
  assign bus.o_pc4         = if_pc4;
  assign bus.o_instruction = if_instr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (default and NB_ADDR=4 builds).
module tb_instruction_fetch;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  instruction_fetch_if #(.NB_ADDR(8)) bus ();
  instruction_fetch_if #(.NB_ADDR(4)) wbus ();

  instruction_fetch #(
    .NB_ADDR  (8),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  instruction_fetch #(
    .NB_ADDR  (4),
    .RESET_PC (32'h0000_0000)
  ) u_wrap (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_if(input string tag, input logic [31:0] pc,
                          input logic [31:0] instr, input logic [31:0] pc4);
    check({tag, ".pc"}, bus.o_pc, pc);
    check({tag, ".instr"}, bus.o_instruction, instr);
    check({tag, ".pc4"}, bus.o_pc4, pc4);
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    bus.i_prog_we   = 1'b1;
    bus.i_prog_addr = addr;
    bus.i_prog_data = data;
    step();
    bus.i_prog_we   = 1'b0;
  endtask

  task automatic wload(input logic [3:0] addr, input logic [31:0] data);
    wbus.i_prog_we   = 1'b1;
    wbus.i_prog_addr = addr;
    wbus.i_prog_data = data;
    step();
    wbus.i_prog_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.i_enable = 1'b0; bus.i_stall = 1'b0; bus.i_jump = 1'b0; bus.i_jump_addr = '0;
    bus.i_prog_we = 1'b0; bus.i_prog_addr = '0; bus.i_prog_data = '0;
    wbus.i_enable = 1'b0; wbus.i_stall = 1'b0; wbus.i_jump = 1'b0; wbus.i_jump_addr = '0;
    wbus.i_prog_we = 1'b0; wbus.i_prog_addr = '0; wbus.i_prog_data = '0;
    step();
    check_if("reset", 32'h0, 32'h0, 32'h0);
    check("reset.halt", {31'b0, bus.o_halt}, 32'h0);

    // Load with enable high: the write strobe must hold PC
    rst = 1'b1;
    bus.i_enable = 1'b1;
    load(8'd0,  32'h2001_0005);
    load(8'd1,  32'h2002_0007);
    load(8'd2,  32'h0022_1820);
    load(8'd3,  32'hFFFF_FFFF);
    load(8'd8,  32'h8C0A_0004);
    load(8'd9,  32'h012A_4020);
    load(8'd16, 32'hAC0B_0008);
    load(8'd17, 32'h3C0C_1234);
    load(8'd18, 32'hDEAD_BEEF);
    check_if("load_hold", 32'h0, 32'h0, 32'h0);

    step(); check_if("run1", 32'h4, 32'h2001_0005, 32'h4);
    step(); check_if("run2", 32'h8, 32'h2002_0007, 32'h8);
    step(); check_if("run3", 32'hC, 32'h0022_1820, 32'hC);

    step();
`ifdef IFETCH_HALT_EN
    check_if("halt_fetch", 32'hC, 32'hFFFF_FFFF, 32'h10);
    check("halt_set", {31'b0, bus.o_halt}, 32'h1);
    for (int i = 0; i < 12; i++) step();
    check_if("halt_frozen", 32'hC, 32'hFFFF_FFFF, 32'h10);
    check("halt_sticky", {31'b0, bus.o_halt}, 32'h1);
`else
    check_if("halt_plain", 32'h10, 32'hFFFF_FFFF, 32'h10);
    check("halt_tied", {31'b0, bus.o_halt}, 32'h0);
`endif

    rst = 1'b0;
    step();
    check_if("midreset", 32'h0, 32'h0, 32'h0);
    check("midreset.halt", {31'b0, bus.o_halt}, 32'h0);
    rst = 1'b1;
    step(); check_if("retained1", 32'h4, 32'h2001_0005, 32'h4);
    step(); check_if("retained2", 32'h8, 32'h2002_0007, 32'h8);

    // Taken branch at pc 0x8: one bubble, then target
    bus.i_jump = 1'b1; bus.i_jump_addr = 32'h20;
    step(); check_if("jump_bubble", 32'h20, 32'h0, 32'h0);
    bus.i_jump = 1'b0;
    step(); check_if("jump_target", 32'h24, 32'h8C0A_0004, 32'h24);

    // Stall with jump held: no redirect until stall drops
    bus.i_stall = 1'b1; bus.i_jump = 1'b1; bus.i_jump_addr = 32'h40;
    step(); check_if("stall_jump1", 32'h24, 32'h8C0A_0004, 32'h24);
    step(); check_if("stall_jump2", 32'h24, 32'h8C0A_0004, 32'h24);
    bus.i_stall = 1'b0;
    step(); check_if("stall_release", 32'h40, 32'h0, 32'h0);
    bus.i_jump = 1'b0;
    step(); check_if("stall_target", 32'h44, 32'hAC0B_0008, 32'h44);

    bus.i_enable = 1'b0;
    step(); step();
    check_if("disable_hold", 32'h44, 32'hAC0B_0008, 32'h44);
    bus.i_enable = 1'b1;

    bus.i_stall = 1'b1;
    step(); check_if("stall_plain", 32'h44, 32'hAC0B_0008, 32'h44);
    bus.i_stall = 1'b0;
    step(); check_if("stall_resume", 32'h48, 32'h3C0C_1234, 32'h48);

    // Overwrite the word at the current PC: fetch blocked that cycle
    load(8'd18, 32'h35AD_00FF);
    check_if("write_same", 32'h48, 32'h3C0C_1234, 32'h48);
    step(); check_if("write_fetch", 32'h4C, 32'h35AD_00FF, 32'h4C);

    // Reset during a load: write still lands
    rst = 1'b0;
    load(8'd19, 32'h0123_4567);
    check_if("reset_load", 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    bus.i_jump = 1'b1; bus.i_jump_addr = 32'h4C;
    step();
    bus.i_jump = 1'b0;
    step(); check_if("reset_load_data", 32'h50, 32'h0123_4567, 32'h50);
    bus.i_enable = 1'b0;

    // Wrap checks on the NB_ADDR=4 instance
    wbus.i_enable = 1'b1;
    wload(4'd0,  32'hA000_0000);
    wload(4'd1,  32'hA000_0001);
    wload(4'd15, 32'hA000_000F);
    check("wrap.load_pc", wbus.o_pc, 32'h0);
    wbus.i_jump = 1'b1; wbus.i_jump_addr = 32'h40;
    step();
    wbus.i_jump = 1'b0;
    step();
    check("wrap.alias_instr", wbus.o_instruction, 32'hA000_0000);
    check("wrap.alias_pc", wbus.o_pc, 32'h44);
    wbus.i_jump = 1'b1; wbus.i_jump_addr = 32'hFFFF_FFFC;
    step();
    wbus.i_jump = 1'b0;
    step();
    check("wrap.top_instr", wbus.o_instruction, 32'hA000_000F);
    check("wrap.top_pc", wbus.o_pc, 32'h0);
    check("wrap.top_pc4", wbus.o_pc4, 32'h0);
    step();
    check("wrap.zero_instr", wbus.o_instruction, 32'hA000_0000);
    check("wrap.zero_pc", wbus.o_pc, 32'h4);
    check("wrap.main_idle", bus.o_pc, 32'h50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
